wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter on the register-file write port. Collects completed results from the ALU pipe and the load/store unit (LSU) over valid/ready handshakes, buffers load results in a small FIFO, and issues at most one registered write per cycle as `write_request`/`w_addr`/`w_data` to the register file. It sits between the execute/memory stages and the register file, on the write side of the file's read/write interface.

## Interface
Parameters:
- `DATA_W`, 32, result width (matches register width)
- `ADDR_W`, 5, register index width
- `LQ_DEPTH`, 2, load-result FIFO entries (power of two, ≥2)

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `alu_valid`  in  1  ALU result present
- `alu_ready`  out  1  ALU result accepted this cycle when high with `alu_valid`
- `alu_rd`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `lsu_valid`  in  1  load result present
- `lsu_ready`  out  1  load result accepted when high with `lsu_valid`
- `lsu_rd`  in  ADDR_W  load destination register
- `lsu_data`  in  DATA_W  load data
- `write_request`  out  1  registered write strobe to register file
- `w_addr`  out  ADDR_W  registered write index
- `w_data`  out  DATA_W  registered write data
- `lq_count`  out  clog2(LQ_DEPTH)+1  current FIFO occupancy

## Operation
- Transfer happens on a rising edge where valid && ready.
- LSU side: `lsu_ready = (count != LQ_DEPTH)`, derived from registered count only (no pop-through). Accepted loads push into the FIFO.
- Arbitration each cycle, one winner:
  - FIFO full: FIFO head wins, `alu_ready = 0` (starvation guard).
  - Otherwise `alu_ready = 1`; ALU wins if `alu_valid`; else FIFO head wins if non-empty; else no write.
- Winner is loaded into the output register; otherwise `write_request` drops to 0 next cycle (`w_addr`/`w_data` hold their last values).
- Destination x0: the transfer completes normally (handshake, FIFO push/pop) but the output register loads `write_request = 0`.
- Push and pop in the same cycle are allowed: count unchanged, pointers both advance.
- Pointers are `clog2(LQ_DEPTH)` bits and wrap modulo `LQ_DEPTH`. Count tracks full/empty.
- Results are written in arbitration order. No ordering is enforced between the ALU and LSU streams; upstream hazard logic owns WAW ordering.

## Timing
- Reset (`rst` low, asynchronous): `write_request = 0`, `w_addr = 0`, `w_data = 0`, `lq_count = 0`, FIFO pointers 0. In-flight results are discarded.
- During reset `alu_ready = 0` and `lsu_ready = 0`.
- ALU latency: accepted at edge N, `write_request` high during cycle N+1. The register file commits at edge N+2 and forwards internally during cycle N+1.
- Load latency, best case: pushed at edge N, popped at edge N+1, `write_request` high during cycle N+2.
- Throughput: one write per cycle sustained.
- `alu_ready` is combinational from registered count only. It never depends on `alu_valid`.

## Configuration
- `WB_STALL_CNT_EN`:
  - Defined: adds output port `stall_cnt` (32 bits). It increments, saturating at 0xFFFF_FFFF, on every cycle with `alu_valid && !alu_ready`. It resets to 0.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package/header `config.v` holds `DATA_W`/`ADDR_W` defaults (`RegBus`, `RegAddrBus` widths), the zero-register index constant, and `WB_STALL_CNT_EN`.
- One sub-module: `wb_fifo`, a parameterised synchronous FIFO. It holds `{rd, data}` entries with push, pop, full, empty and count outputs. The arbitration and output register stay in `wb_arbiter`.

## Test plan
- Reset mid-stream: FIFO holding 2 loads, assert `rst` low between edges → outputs 0 immediately, `lq_count = 0`. After release, no stale write occurs.
- ALU only: `alu_valid` for 3 cycles, rd = 1,2,3, data = 0x11,0x22,0x33 → `write_request` high in cycles N+1..N+3 with matching addr/data, then low.
- Load only: one load, rd = 5, data = 0xDEAD_BEEF, at edge N → `w_addr = 5`, `w_data = 0xDEADBEEF`, `write_request` high in cycle N+2 only.
- Contention: `alu_valid` continuous plus 3 loads → 2 loads accepted, then `lsu_ready = 0`, then `alu_ready = 0` for one cycle while the FIFO head is written. The third load is accepted afterwards. All 3 loads are written in order.
- x0 filtering: ALU rd = 0 with data 0xFFFF_FFFF → `alu_ready = 1`, `write_request` stays 0. A load with rd = 0 pops with no write.
- With `WB_STALL_CNT_EN`: FIFO held full for 4 cycles with `alu_valid` → `stall_cnt` rises by the number of cycles `alu_ready` is low (4 with constant load pressure).

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: default widths, the zero-register
// index and the winner-source encoding used by the arbitration logic.
package wb_arbiter_pkg;

    localparam int WB_DATA_W   = 32;  // RegBus width
    localparam int WB_ADDR_W   = 5;   // RegAddrBus width
    localparam int WB_LQ_DEPTH = 2;

    // Writes to this index are architecturally discarded (x0 is hardwired to zero).
    localparam int unsigned WB_ZERO_REG = 0;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LQ   = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding {rd, data} load results. Head is read
// combinationally so a pushed entry can be popped on the very next edge.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage carries no reset: an entry is only observable after it has been pushed.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= push_data;
                end
            end

            assign mem[gi] = entry_reg;
        end
    endgenerate

    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered load results into one
// registered register-file write per cycle. Optional WB_STALL_CNT_EN adds stall_cnt.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_W   = WB_DATA_W,
    parameter int ADDR_W   = WB_ADDR_W,
    parameter int LQ_DEPTH = WB_LQ_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alu_valid,
    output logic                        alu_ready,
    input  logic [ADDR_W-1:0]           alu_rd,
    input  logic [DATA_W-1:0]           alu_data,
    input  logic                        lsu_valid,
    output logic                        lsu_ready,
    input  logic [ADDR_W-1:0]           lsu_rd,
    input  logic [DATA_W-1:0]           lsu_data,
    output logic                        write_request,
    output logic [ADDR_W-1:0]           w_addr,
    output logic [DATA_W-1:0]           w_data,
    output logic [$clog2(LQ_DEPTH):0]   lq_count
`ifdef WB_STALL_CNT_EN
    ,
    output logic [31:0]                 stall_cnt
`endif
);

    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic               lq_full;
    logic               lq_empty;
    logic               lq_push;
    logic               lq_pop;
    logic [ENTRY_W-1:0] lq_head;
    logic [ADDR_W-1:0]  lq_head_rd;
    logic [DATA_W-1:0]  lq_head_data;

    logic               arb_alu_ready;
    wb_src_e            win_src;
    logic [ADDR_W-1:0]  win_rd;
    logic [DATA_W-1:0]  win_data;

    logic               write_request_reg;
    logic [ADDR_W-1:0]  w_addr_reg;
    logic [DATA_W-1:0]  w_data_reg;

    // Readiness derives from registered occupancy only, so a pop this cycle
    // never frees a slot for a same-cycle push.
    assign lq_push = lsu_valid && !lq_full;

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk       (clk),
        .rst       (rst),
        .push      (lq_push),
        .push_data ({lsu_rd, lsu_data}),
        .pop       (lq_pop),
        .pop_data  (lq_head),
        .full      (lq_full),
        .empty     (lq_empty),
        .count     (lq_count)
    );

    assign {lq_head_rd, lq_head_data} = lq_head;

    // A full load queue takes priority so the ALU stream cannot starve loads.
    always_comb begin
        arb_alu_ready = 1'b0;
        lq_pop        = 1'b0;
        win_src       = SRC_NONE;
        if (lq_full) begin
            lq_pop  = 1'b1;
            win_src = SRC_LQ;
        end else begin
            arb_alu_ready = 1'b1;
            if (alu_valid) begin
                win_src = SRC_ALU;
            end else if (!lq_empty) begin
                lq_pop  = 1'b1;
                win_src = SRC_LQ;
            end
        end
    end

    always_comb begin
        win_rd   = '0;
        win_data = '0;
        case (win_src)
            SRC_ALU: begin
                win_rd   = alu_rd;
                win_data = alu_data;
            end
            SRC_LQ: begin
                win_rd   = lq_head_rd;
                win_data = lq_head_data;
            end
            default: begin
                win_rd   = '0;
                win_data = '0;
            end
        endcase
    end

    // Handshakes are masked while reset is asserted; the state itself is held by reset.
    assign alu_ready = rst && arb_alu_ready;
    assign lsu_ready = rst && !lq_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_request_reg <= 1'b0;
            w_addr_reg        <= '0;
            w_data_reg        <= '0;
        end else if (win_src != SRC_NONE) begin
            // x0 destinations still consume the slot but never strobe the write.
            write_request_reg <= (win_rd != ADDR_W'(WB_ZERO_REG));
            w_addr_reg        <= win_rd;
            w_data_reg        <= win_data;
        end else begin
            write_request_reg <= 1'b0;
        end
    end

    assign write_request = write_request_reg;
    assign w_addr        = w_addr_reg;
    assign w_data        = w_data_reg;

`ifdef WB_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
        end else if (alu_valid && !arb_alu_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: reset, ALU-only, load-only,
// contention, x0 filtering, reset mid-stream and (optionally) the stall counter.
module tb_wb_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int LQ_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              alu_valid = 1'b0;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              lsu_valid = 1'b0;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_rd = '0;
    logic [DATA_W-1:0] lsu_data = '0;
    logic              write_request;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [1:0]        lq_count;
`ifdef WB_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .LQ_DEPTH (LQ_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .lsu_valid     (lsu_valid),
        .lsu_ready     (lsu_ready),
        .lsu_rd        (lsu_rd),
        .lsu_data      (lsu_data),
        .write_request (write_request),
        .w_addr        (w_addr),
        .w_data        (w_data),
        .lq_count      (lq_count)
`ifdef WB_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Contention script: per cycle inputs and the outputs expected right after that edge.
    localparam int NC = 8;
    logic              c_alu_v   [NC] = '{1, 1, 1, 1, 1, 1, 0, 0};
    logic [ADDR_W-1:0] c_alu_rd  [NC] = '{10, 11, 12, 12, 13, 13, 0, 0};
    logic              c_lsu_v   [NC] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic [ADDR_W-1:0] c_lsu_rd  [NC] = '{20, 21, 22, 22, 0, 0, 0, 0};
    logic              c_alu_rdy [NC] = '{1, 1, 0, 1, 0, 1, 1, 1};
    logic              c_lsu_rdy [NC] = '{1, 1, 0, 1, 0, 1, 1, 1};
    logic              c_wr      [NC] = '{1, 1, 1, 1, 1, 1, 1, 0};
    logic [ADDR_W-1:0] c_addr    [NC] = '{10, 11, 20, 12, 21, 13, 22, 22};
    logic [1:0]        c_cnt     [NC] = '{1, 2, 1, 2, 1, 1, 0, 0};

    function automatic logic [DATA_W-1:0] alu_val(input logic [ADDR_W-1:0] rd);
        return 32'hA000_0000 | 32'(rd);
    endfunction

    function automatic logic [DATA_W-1:0] lsu_val(input logic [ADDR_W-1:0] rd);
        return 32'hB000_0000 | 32'(rd);
    endfunction

    initial begin
        // Reset state
        #2;
        check("rst_wreq", 64'(write_request), 64'd0);
        check("rst_waddr", 64'(w_addr), 64'd0);
        check("rst_wdata", 64'(w_data), 64'd0);
        check("rst_count", 64'(lq_count), 64'd0);
        check("rst_alu_ready", 64'(alu_ready), 64'd0);
        check("rst_lsu_ready", 64'(lsu_ready), 64'd0);
        step();
        step();
        rst = 1'b1;
        #1;
        check("rel_alu_ready", 64'(alu_ready), 64'd1);
        check("rel_lsu_ready", 64'(lsu_ready), 64'd1);
        step();

        // ALU only: rd 1..3, data 0x11..0x33
        for (int i = 1; i <= 3; i++) begin
            alu_valid = 1'b1;
            alu_rd    = ADDR_W'(i);
            alu_data  = 32'(i * 32'h11);
            #1;
            check($sformatf("alu%0d_ready", i), 64'(alu_ready), 64'd1);
            step();
            check($sformatf("alu%0d_wreq", i), 64'(write_request), 64'd1);
            check($sformatf("alu%0d_waddr", i), 64'(w_addr), 64'(i));
            check($sformatf("alu%0d_wdata", i), 64'(w_data), 64'(i * 32'h11));
        end
        alu_valid = 1'b0;
        step();
        check("alu_idle_wreq", 64'(write_request), 64'd0);
        check("alu_idle_waddr_hold", 64'(w_addr), 64'd3);

        // Load only: push at N, write during N+2 only
        lsu_valid = 1'b1;
        lsu_rd    = 5;
        lsu_data  = 32'hDEAD_BEEF;
        #1;
        check("ld_lsu_ready", 64'(lsu_ready), 64'd1);
        step();
        lsu_valid = 1'b0;
        check("ld_n1_wreq", 64'(write_request), 64'd0);
        check("ld_n1_count", 64'(lq_count), 64'd1);
        step();
        check("ld_n2_wreq", 64'(write_request), 64'd1);
        check("ld_n2_waddr", 64'(w_addr), 64'd5);
        check("ld_n2_wdata", 64'(w_data), 64'hDEAD_BEEF);
        check("ld_n2_count", 64'(lq_count), 64'd0);
        step();
        check("ld_n3_wreq", 64'(write_request), 64'd0);

        // Contention: continuous ALU traffic plus three loads
        for (int c = 0; c < NC; c++) begin
            alu_valid = c_alu_v[c];
            alu_rd    = c_alu_rd[c];
            alu_data  = alu_val(c_alu_rd[c]);
            lsu_valid = c_lsu_v[c];
            lsu_rd    = c_lsu_rd[c];
            lsu_data  = lsu_val(c_lsu_rd[c]);
            #1;
            check($sformatf("ct%0d_alu_ready", c), 64'(alu_ready), 64'(c_alu_rdy[c]));
            check($sformatf("ct%0d_lsu_ready", c), 64'(lsu_ready), 64'(c_lsu_rdy[c]));
            step();
            check($sformatf("ct%0d_wreq", c), 64'(write_request), 64'(c_wr[c]));
            check($sformatf("ct%0d_waddr", c), 64'(w_addr), 64'(c_addr[c]));
            check($sformatf("ct%0d_wdata", c), 64'(w_data),
                  64'((c_addr[c] >= 20) ? lsu_val(c_addr[c]) : alu_val(c_addr[c])));
            check($sformatf("ct%0d_count", c), 64'(lq_count), 64'(c_cnt[c]));
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;

        // x0 filtering: ALU write to x0 is accepted but never strobed
        alu_valid = 1'b1;
        alu_rd    = 0;
        alu_data  = 32'hFFFF_FFFF;
        #1;
        check("x0_alu_ready", 64'(alu_ready), 64'd1);
        step();
        alu_valid = 1'b0;
        check("x0_alu_wreq", 64'(write_request), 64'd0);
        lsu_valid = 1'b1;
        lsu_rd    = 0;
        lsu_data  = 32'h1234_5678;
        step();
        lsu_valid = 1'b0;
        check("x0_ld_count_push", 64'(lq_count), 64'd1);
        step();
        check("x0_ld_count_pop", 64'(lq_count), 64'd0);
        check("x0_ld_wreq", 64'(write_request), 64'd0);
        step();
        check("x0_ld_wreq_after", 64'(write_request), 64'd0);

        // Reset mid-stream with two loads buffered behind ALU traffic
        alu_valid = 1'b1;
        alu_rd    = 3;
        alu_data  = alu_val(3);
        lsu_valid = 1'b1;
        lsu_rd    = 7;
        lsu_data  = lsu_val(7);
        step();
        lsu_rd    = 8;
        lsu_data  = lsu_val(8);
        step();
        check("mid_count_full", 64'(lq_count), 64'd2);
        check("mid_wreq_before", 64'(write_request), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_wreq", 64'(write_request), 64'd0);
        check("mid_rst_waddr", 64'(w_addr), 64'd0);
        check("mid_rst_wdata", 64'(w_data), 64'd0);
        check("mid_rst_count", 64'(lq_count), 64'd0);
        check("mid_rst_alu_ready", 64'(alu_ready), 64'd0);
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mid_post%0d_wreq", i), 64'(write_request), 64'd0);
            check($sformatf("mid_post%0d_count", i), 64'(lq_count), 64'd0);
        end

`ifdef WB_STALL_CNT_EN
        // Constant ALU and load pressure from empty: stalls on 4 of 9 cycles.
        check("stall_start", 64'(stall_cnt), 64'd0);
        alu_valid = 1'b1;
        lsu_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            alu_rd   = ADDR_W'(i + 1);
            alu_data = alu_val(ADDR_W'(i + 1));
            lsu_rd   = ADDR_W'(i + 16);
            lsu_data = lsu_val(ADDR_W'(i + 16));
            step();
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        check("stall_cnt", 64'(stall_cnt), 64'd4);
        for (int i = 0; i < 4; i++) step();
        check("stall_cnt_hold", 64'(stall_cnt), 64'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
